fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the 5-stage pipeline. Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with a separate response channel. Holds at most one fetched instruction for the IF/ID register. Obeys `stall_f` from the hazard unit, and on a taken branch from Execute redirects the PC and discards any stale in-flight response.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock, single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `stall_f`  in  1  hazard unit stall; when high, the buffered instruction is not consumed.
- `e_b_taken`  in  1  redirect request from Execute (branch or jump taken).
- `e_b_target`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response valid; responses return in order, with 1 or more cycles of latency.
- `imem_rsp_data`  in  `INSTR_BUS`  fetched instruction.
- `f_valid`  out  1  `f_instr`/`f_pc` hold a valid instruction for IF/ID.
- `f_pc`  out  32  PC of `f_instr`.
- `f_instr`  out  `INSTR_BUS`  instruction word.

## Operation
Internal state:
- `fetch_pc`: next address to request.
- `pend`: one request outstanding.
- `drop`: the outstanding response is stale.
- Buffer registers `buf_valid`, `buf_pc`, `buf_instr`.

FSM states, derived from the registers:
- READY: `!pend && !buf_valid`.
- WAIT: `pend`.
- HOLD: `buf_valid && !pend`.
- DRAIN: `pend && drop`.

Consume and issue rules:
- Consume: `f_valid && !stall_f && !e_b_taken`. On consume, `buf_valid` clears.
- Issue: `imem_req_valid = !rst && !e_b_taken && !pend && (!buf_valid || consume)`.
  - Address is `fetch_pc`.
  - On `imem_req_ready`, set `pend` and update `fetch_pc <= fetch_pc + 4` (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- At most one request is outstanding. There is no new issue while `pend` is set, including in the response cycle.

Response handling:
- On `imem_rsp_valid` with `pend`: clear `pend`.
  - If `drop`, discard the data and clear `drop`.
  - Otherwise load `buf_instr <= imem_rsp_data`, `buf_pc <= address of that request`, and set `buf_valid`.
- `imem_rsp_valid` while `!pend` is a protocol error and is ignored.

Redirect (`e_b_taken`) has the highest priority:
- `fetch_pc <= {e_b_target[31:2],2'b00}` and `buf_valid <= 0`.
- Outstanding-request handling:
  - If `pend` and no response this cycle, set `drop`.
  - If `pend` and a response arrives this cycle, discard it and clear `pend`.
- `imem_req_valid` is forced low in the redirect cycle. A pending unaccepted request is withdrawn; this is legal on this bus.
- A redirect while `stall_f` is high still takes effect.

Request and output stability:
- While `imem_req_valid && !imem_req_ready` and there is no redirect, `imem_req_addr` is held stable.
- While `stall_f` is high, `f_*` hold their values.
- When `!buf_valid`, `f_instr` holds `NOP_INSTR` and `f_pc` holds its last value.

## Timing
- Reset values: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `f_valid=0`, `f_pc=RESET_PC`, `f_instr=NOP_INSTR`, `pend=0`, `drop=0`.
- First request: in the first cycle with `rst` low.
- Latency: request accepted in cycle t, response in t+L, `f_valid` in t+L+1 (buffer is registered).
- With L=1 and no stalls, throughput is 1 instruction per 2 cycles. The next request issues combinationally in the consume cycle.
- Reset asserted mid-operation: all state clears in that cycle. A response arriving after reset with `pend=0` is ignored.
- `f_valid`, `f_pc`, `f_instr` are driven directly from registers. `imem_req_valid` depends combinationally on `stall_f` and `e_b_taken`.

## Structure
- Add `NOP_INSTR` (32'h0000_0013) and `RESET_PC_DEFAULT` to `defines.sv`; reuse `INSTR_BUS`.
- Single module, no sub-modules. The address of the outstanding request is kept in a register `pend_pc`.

## Test plan
- Reset, then `imem_req_ready=1` with L=1 memory returning `addr^32'hA5A5_0000`, `stall_f=0` → requests to 0x0, 0x4, 0x8 on alternating cycles; `f_pc`/`f_instr` = 0x0/0xA5A5_0000, 0x4/0xA5A5_0004, and so on.
- Hold `stall_f=1` for 5 cycles with `f_valid=1` at PC 0x4 → `f_*` stable, no new request, `fetch_pc` stays 0x8; the request to 0x8 issues in the cycle `stall_f` drops.
- `imem_req_ready=0` for 3 cycles → `imem_req_addr` is held at 0x8 every cycle; accepted on the 4th cycle.
- Use L=3. Request to 0x10 is accepted, then `e_b_taken` with target 0x100 one cycle later → response for 0x10 is dropped (`f_valid` stays 0); the next request is 0x100, and `f_pc=0x100` follows.
- `e_b_taken` with target 0x203 while `buf_valid` and `stall_f=1` → buffer is cleared and the next request address is 0x200; the redirect in the same cycle as a response discards that response.
- `rst` asserted while `pend=1`, with the response arriving the cycle after reset → `f_valid` stays 0; the first request is `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_unit_pkg;

  localparam int          INSTR_BUS        = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch FSM view; decoded from the pend/drop/buf_valid registers.
  typedef enum logic [1:0] {
    ST_READY,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps one request in flight
// on the imem valid/ready channel and buffers one instruction for IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_f,
  input  logic                 e_b_taken,
  input  logic [31:0]          e_b_target,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [31:0]          imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_BUS-1:0] imem_rsp_data,
  output logic                 f_valid,
  output logic [31:0]          f_pc,
  output logic [INSTR_BUS-1:0] f_instr
);

  logic [31:0]          fetch_pc, fetch_pc_n;
  logic [31:0]          pend_pc, pend_pc_n;
  logic                 pend, pend_n;
  logic                 drop, drop_n;
  logic                 buf_valid, buf_valid_n;
  logic [31:0]          buf_pc, buf_pc_n;
  logic [INSTR_BUS-1:0] buf_instr, buf_instr_n;

  fetch_state_t state;
  logic         consume;
  logic         req_fire;

  assign consume  = buf_valid && !stall_f && !e_b_taken;
  assign req_fire = imem_req_valid && imem_req_ready;

  // Decode the FSM state from the control registers (DRAIN takes precedence over WAIT).
  always_comb begin
    if (pend && drop)   state = ST_DRAIN;
    else if (pend)      state = ST_WAIT;
    else if (buf_valid) state = ST_HOLD;
    else                state = ST_READY;
  end

  // State register: reset clears everything, including any in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      pend_pc   <= RESET_PC;
      pend      <= 1'b0;
      drop      <= 1'b0;
      buf_valid <= 1'b0;
      buf_pc    <= RESET_PC;
      buf_instr <= NOP_INSTR;
    end else begin
      fetch_pc  <= fetch_pc_n;
      pend_pc   <= pend_pc_n;
      pend      <= pend_n;
      drop      <= drop_n;
      buf_valid <= buf_valid_n;
      buf_pc    <= buf_pc_n;
      buf_instr <= buf_instr_n;
    end
  end

  // Next-state logic: redirect wins over consume, response capture and issue.
  always_comb begin
    fetch_pc_n  = fetch_pc;
    pend_pc_n   = pend_pc;
    pend_n      = pend;
    drop_n      = drop;
    buf_valid_n = buf_valid;
    buf_pc_n    = buf_pc;
    buf_instr_n = buf_instr;

    if (e_b_taken) begin
      fetch_pc_n  = align_word(e_b_target);
      buf_valid_n = 1'b0;
      buf_instr_n = NOP_INSTR;
      if (pend && !imem_rsp_valid) begin
        drop_n = 1'b1;
      end else if (pend && imem_rsp_valid) begin
        // The response is for the wrong path; throw it away right here.
        pend_n = 1'b0;
        drop_n = 1'b0;
      end
    end else begin
      if (consume) begin
        buf_valid_n = 1'b0;
        buf_instr_n = NOP_INSTR;
      end
      // A response with nothing outstanding is a protocol error and is ignored.
      if (imem_rsp_valid && pend) begin
        pend_n = 1'b0;
        if (drop) begin
          drop_n = 1'b0;
        end else begin
          buf_valid_n = 1'b1;
          buf_pc_n    = pend_pc;
          buf_instr_n = imem_rsp_data;
        end
      end
      // Issue never coincides with a response: it requires pend to be clear.
      if (req_fire) begin
        pend_n     = 1'b1;
        pend_pc_n  = fetch_pc;
        fetch_pc_n = fetch_pc + 32'd4;
      end
    end
  end

  // Outputs: request valid is combinational so the next fetch goes out in the consume cycle.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && !e_b_taken) begin
      case (state)
        ST_READY: imem_req_valid = 1'b1;
        ST_HOLD:  imem_req_valid = consume;
        default:  imem_req_valid = 1'b0;
      endcase
    end
    imem_req_addr = fetch_pc;
    f_valid       = buf_valid;
    f_pc          = buf_pc;
    f_instr       = buf_instr;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model
// returning addr ^ 32'hA5A5_0000.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        e_b_taken;
  logic [31:0] e_b_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Memory model state
  logic        mem_busy = 1'b0;
  int          mem_rem  = 0;
  logic [31:0] mem_addr = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .e_b_taken      (e_b_taken),
    .e_b_target     (e_b_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        taken;
    logic [31:0] tgt;
    logic        rdy;
    int          lat;
    logic        rv;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare after settling, advance memory at posedge.
  task automatic step(input logic r, input logic s, input logic t, input logic [31:0] tg,
                      input logic rdy, input int lat, input logic chk,
                      input logic erv, input logic [31:0] eaddr, input logic efv,
                      input logic [31:0] epc, input logic [31:0] einstr);
    logic        fire;
    logic [31:0] faddr;
    @(negedge clk);
    cyc++;
    rst            = r;
    stall_f        = s;
    e_b_taken      = t;
    e_b_target     = tg;
    imem_req_ready = rdy;
    imem_rsp_valid = mem_busy && (mem_rem == 1);
    imem_rsp_data  = mem_busy ? (mem_addr ^ MAGIC) : 32'hDEAD_BEEF;
    #1;
    if (chk) begin
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
      check("req_addr",  imem_req_addr, eaddr);
      check("f_valid",   {31'b0, f_valid}, {31'b0, efv});
      check("f_pc",      f_pc, epc);
      check("f_instr",   f_instr, einstr);
    end
    fire  = imem_req_valid && imem_req_ready;
    faddr = imem_req_addr;
    @(posedge clk);
    if (mem_busy) begin
      mem_rem--;
      if (mem_rem == 0) mem_busy = 1'b0;
    end
    if (fire) begin
      mem_busy = 1'b1;
      mem_rem  = lat;
      mem_addr = faddr;
    end
  endtask

  function automatic vec_t v(input logic s, input logic t, input logic [31:0] tg, input logic rdy,
                             input int lat, input logic rv, input logic [31:0] addr,
                             input logic fv, input logic [31:0] pc, input logic [31:0] instr);
    vec_t x;
    x.rst = 1'b0; x.stall = s; x.taken = t; x.tgt = tg; x.rdy = rdy; x.lat = lat;
    x.rv = rv; x.addr = addr; x.fv = fv; x.pc = pc; x.instr = instr;
    return x;
  endfunction

  initial begin
    rst = 1'b1; stall_f = 1'b0; e_b_taken = 1'b0; e_b_target = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset: first cycle unchecked, second cycle shows reset values
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 32'h0, NOP);

    // L=1 streaming, stall hold, ready backpressure
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 32'h0,  0, 32'h0, NOP));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 32'h4,  0, 32'h0, NOP));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 32'h4,  1, 32'h0, 32'hA5A5_0000));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 32'h8,  0, 32'h0, NOP));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(1, 0, 0, 1, 1, 0, 32'h8, 1, 32'h4, 32'hA5A5_0004));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h8,  1, 32'h4, 32'hA5A5_0004));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h8,  0, 32'h4, NOP));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h8,  0, 32'h4, NOP));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 32'h8,  0, 32'h4, NOP));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 32'hC,  0, 32'h4, NOP));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 32'hC,  1, 32'h8, 32'hA5A5_0008));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 32'h10, 0, 32'h8, NOP));
    // L=3, redirect one cycle after the request to 0x10 is accepted
    vecs.push_back(v(0, 0, 0, 1, 3, 1, 32'h10, 1, 32'hC, 32'hA5A5_000C));
    vecs.push_back(v(0, 1, 32'h100, 1, 3, 0, 32'h14, 0, 32'hC, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 32'h100, 0, 32'hC, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 32'h100, 0, 32'hC, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 1, 32'h100, 0, 32'hC, NOP));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0, 1, 3, 0, 32'h104, 0, 32'hC, NOP));
    // Redirect to 0x203 while holding under stall
    vecs.push_back(v(1, 0, 0, 1, 3, 0, 32'h104, 1, 32'h100, 32'hA5A5_0100));
    vecs.push_back(v(1, 1, 32'h203, 1, 3, 0, 32'h104, 1, 32'h100, 32'hA5A5_0100));
    vecs.push_back(v(0, 0, 0, 1, 3, 1, 32'h200, 0, 32'h100, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 32'h204, 0, 32'h100, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 32'h204, 0, 32'h100, NOP));
    // Redirect in the same cycle as the response for 0x200
    vecs.push_back(v(0, 1, 32'h300, 1, 3, 0, 32'h204, 0, 32'h100, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 1, 32'h300, 0, 32'h100, NOP));
    vecs.push_back(v(0, 0, 0, 1, 3, 0, 32'h304, 0, 32'h100, NOP));

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].stall, vecs[i].taken, vecs[i].tgt, vecs[i].rdy, vecs[i].lat, 1,
           vecs[i].rv, vecs[i].addr, vecs[i].fv, vecs[i].pc, vecs[i].instr);

    // Reset while a request is pending; its response lands in the first cycle after reset
    step(1, 0, 0, 0, 1, 3, 1, 0, 32'h304, 0, 32'h100, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 1, 32'h0, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 0, 32'h4, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 0, 32'h4, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 0, 32'h4, 0, 32'h0, NOP);

    // Redirect to the top word, then fetch PC wraps to zero
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 3, 1, 0, 32'h4, 1, 32'h0, 32'hA5A5_0000);
    step(0, 0, 0, 0, 1, 3, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 0, 32'h0, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 0, 32'h0, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 0, 32'h0, 0, 32'h0, NOP);
    step(0, 0, 0, 0, 1, 3, 1, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
